// File: rtl/popcount_frame_accum.sv
// Per-frame bit-density accumulator: popcounts each accepted 32-bit word in a
// registered stage, sums counts and words until LAST, then emits one result.
module popcount_frame_accum #(
  parameter int SUM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [31:0]      i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [SUM_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_words,
  output logic             o_ovf
);

  function automatic logic [5:0] popcount32(input logic [31:0] w);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, w[i]};
    return c;
  endfunction

  logic             en;
  logic             xfer;
  logic             s1_valid;
  logic [5:0]       s1_cnt;
  logic             s1_last;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] wcnt;
  logic             ovf;

  logic [SUM_W:0]   sum_wide;
  logic [CNT_W:0]   wc_wide;
  logic [SUM_W-1:0] sum_n;
  logic [CNT_W-1:0] wc_n;
  logic             ovf_n;
  logic             load;

  // A stalled result freezes the whole pipe, so nothing upstream can be lost.
  assign en      = !(o_valid && !o_ready);
  assign i_ready = rst_n && en;
  assign xfer    = i_valid && i_ready;
  assign load    = en && s1_valid && s1_last;

  assign sum_wide = {1'b0, acc} + {{(SUM_W-5){1'b0}}, s1_cnt};
  assign wc_wide  = {1'b0, wcnt} + {{CNT_W{1'b0}}, 1'b1};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sum_n = sum_wide[SUM_W-1:0];
    wc_n  = wc_wide[CNT_W-1:0];
    ovf_n = ovf;
    if (sum_wide[SUM_W]) begin
      sum_n = '1;
      ovf_n = 1'b1;
    end
    if (wc_wide[CNT_W]) begin
      wc_n  = '1;
      ovf_n = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_cnt  <= popcount32(i_data);
        s1_last <= i_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      wcnt <= '0;
      ovf  <= 1'b0;
    end else if (en && s1_valid) begin
      if (s1_last) begin
        acc  <= '0;
        wcnt <= '0;
        ovf  <= 1'b0;
      end else begin
        acc  <= sum_n;
        wcnt <= wc_n;
        ovf  <= ovf_n;
      end
    end
  end

  // A new result may load in the same cycle the old one is taken: no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_words <= '0;
      o_ovf   <= 1'b0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_sum   <= sum_n;
      o_words <= wc_n;
      o_ovf   <= ovf_n;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed and randomized checks of popcount_frame_accum; a second instance
// with an 8-bit sum exercises saturation on the same stimulus.
module tb_popcount_frame_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_last = 1'b0;
  logic        o_ready = 1'b0;

  logic        i_ready, o_valid, o_ovf;
  logic [15:0] o_sum, o_words;
  logic        i_ready8, o_valid8, o_ovf8;
  logic [7:0]  o_sum8;
  logic [15:0] o_words8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount_frame_accum #(.SUM_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready),
    .o_sum(o_sum), .o_words(o_words), .o_ovf(o_ovf)
  );

  popcount_frame_accum #(.SUM_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready8),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid8), .o_ready(o_ready),
    .o_sum(o_sum8), .o_words(o_words8), .o_ovf(o_ovf8)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_last  = l;
  endtask

  task automatic put(input logic [31:0] d, input logic l, output logic rdy);
    drive(1'b1, d, l);
    @(negedge clk);
    rdy = i_ready;
  endtask

  task automatic wait_valid(input int max, output bit seen);
    seen = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_valid) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 1'b1;
    i_data = 32'hFFFF_FFFF;
    i_last = 1'b1;
    o_ready = 1'b1;
    #12;
    checks++;
    if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
    checks++;
    if (o_valid !== 1'b0 || o_valid8 !== 1'b0) begin
      errors++; $display("FAIL reset_o_valid: got %b/%b want 0/0", o_valid, o_valid8);
    end
    checks++;
    if (o_sum !== 16'd0 || o_words !== 16'd0 || o_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got sum=%0d words=%0d ovf=%b want 0 0 0", o_sum, o_words, o_ovf);
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", i_ready); end
  endtask

  task automatic test_single_word();
    logic r;
    o_ready = 1'b1;
    put(32'hFFFF_FFFF, 1'b1, r);
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", r); end
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got o_valid=%b want 0", o_valid); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 16'd32 || o_words !== 16'd1 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got v=%b sum=%0d words=%0d ovf=%b want 1 32 1 0", o_valid, o_sum, o_words, o_ovf);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got o_valid=%b want 0", o_valid); end
  endtask

  task automatic test_frame();
    logic [31:0] words [4];
    logic r;
    bit all_rdy, seen;
    words[0] = 32'h0000_0001;
    words[1] = 32'h8000_0000;
    words[2] = 32'h5555_5555;
    words[3] = 32'h0000_0000;
    all_rdy = 1;
    o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(words[i], (i == 3), r);
      if (r !== 1'b1) all_rdy = 0;
    end
    drive(1'b0, 32'h0, 1'b0);
    wait_valid(6, seen);
    checks++;
    if (!all_rdy) begin errors++; $display("FAIL frame_ready: got a stall want i_ready=1 throughout"); end
    checks++;
    if (!seen || o_sum !== 16'd18 || o_words !== 16'd4 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL frame_result: got v=%b sum=%0d words=%0d ovf=%b want 1 18 4 0", seen, o_sum, o_words, o_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic r;
    bit seen;
    o_ready = 1'b1;
    for (int i = 0; i < 9; i++) put(32'hFFFF_FFFF, (i == 8), r);
    drive(1'b0, 32'h0, 1'b0);
    wait_valid(6, seen);
    checks++;
    if (!seen || o_valid8 !== 1'b1 || o_sum8 !== 8'd255 || o_words8 !== 16'd9 || o_ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL sat_result: got v=%b sum=%0d words=%0d ovf=%b want 1 255 9 1", o_valid8, o_sum8, o_words8, o_ovf8);
    end
    checks++;
    if (o_sum !== 16'd288 || o_words !== 16'd9 || o_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_wide: got sum=%0d words=%0d ovf=%b want 288 9 0", o_sum, o_words, o_ovf);
    end
    put(32'h0000_000F, 1'b1, r);
    drive(1'b0, 32'h0, 1'b0);
    wait_valid(6, seen);
    checks++;
    if (!seen || o_sum8 !== 8'd4 || o_words8 !== 16'd1 || o_ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL sat_next_frame: got v=%b sum=%0d words=%0d ovf=%b want 1 4 1 0", seen, o_sum8, o_words8, o_ovf8);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic r1, r2;
    bit stable, quiet;
    o_ready = 1'b0;
    put(32'h0000_00FF, 1'b1, r1);
    put(32'h0000_0003, 1'b1, r2);
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b%b want 11", r1, r2); end
    // Offer a word while stalled; it must never be taken.
    drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_valid !== 1'b1 || o_sum !== 16'd8 || o_words !== 16'd1 || i_ready !== 1'b0) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL b2b_stall: got v=%b sum=%0d ready=%b want 1 8 0 held", o_valid, o_sum, i_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 16'd8 || o_words !== 16'd1) begin
      errors++; $display("FAIL b2b_first: got v=%b sum=%0d words=%0d want 1 8 1", o_valid, o_sum, o_words);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 16'd2 || o_words !== 16'd1) begin
      errors++; $display("FAIL b2b_second: got v=%b sum=%0d words=%0d want 1 2 1", o_valid, o_sum, o_words);
    end
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_valid !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL b2b_no_extra: got o_valid=%b sum=%0d want no further result", o_valid, o_sum); end
  endtask

  task automatic test_reset_mid_frame();
    logic r;
    bit seen;
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) put(32'hFFFF_FFFF, 1'b0, r);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (i_ready !== 1'b0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state: got ready=%b v=%b want 0 0", i_ready, o_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    put(32'h0000_0007, 1'b1, r);
    drive(1'b0, 32'h0, 1'b0);
    wait_valid(6, seen);
    checks++;
    if (!seen || o_sum !== 16'd3 || o_words !== 16'd1 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result: got v=%b sum=%0d words=%0d ovf=%b want 1 3 1 0", seen, o_sum, o_words, o_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int exp_sum[$];
    int exp_words[$];
    int received;
    bit prod_done;
    received = 0;
    prod_done = 0;
    fork
      begin : producer
        for (int f = 0; f < 1000; f++) begin
          int len, sum, wait_cnt;
          logic [31:0] d;
          len = $urandom_range(1, 20);
          sum = 0;
          for (int w = 0; w < len; w++) begin
            while ($urandom_range(0, 3) == 0) drive(1'b0, $urandom, 1'($urandom_range(0, 1)));
            d = $urandom;
            wait_cnt = 0;
            drive(1'b1, d, (w == len - 1));
            @(negedge clk);
            while (i_ready !== 1'b1 && wait_cnt < 200) begin
              drive(1'b1, d, (w == len - 1));
              @(negedge clk);
              wait_cnt++;
            end
            if (wait_cnt >= 200) begin
              checks++;
              errors++;
              $display("FAIL rand_input_timeout: got i_ready=0 for 200 cycles want acceptance");
              f = 1000;
              break;
            end
            sum += $countones(d);
          end
          if (f < 1000) begin
            exp_sum.push_back(sum);
            exp_words.push_back(len);
          end
        end
        drive(1'b0, 32'h0, 1'b0);
        prod_done = 1;
      end
      begin : consumer
        int cycles;
        cycles = 0;
        while (received < 1000 && cycles < 80000 && !(prod_done && exp_sum.size() == 0 && !o_valid)) begin
          @(posedge clk);
          #1;
          o_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (o_valid && o_ready) begin
            checks++;
            if (exp_sum.size() == 0) begin
              errors++; $display("FAIL rand_unexpected: got sum=%0d words=%0d want no result", o_sum, o_words);
            end else begin
              int es, ew;
              es = exp_sum.pop_front();
              ew = exp_words.pop_front();
              if (o_sum !== 16'(es) || o_words !== 16'(ew) || o_ovf !== 1'b0) begin
                errors++;
                $display("FAIL rand_frame%0d: got sum=%0d words=%0d ovf=%b want %0d %0d 0",
                         received, o_sum, o_words, o_ovf, es, ew);
              end
            end
            received++;
          end
          cycles++;
        end
      end
    join
    checks++;
    if (received != 1000) begin errors++; $display("FAIL rand_count: got %0d results want 1000", received); end
    o_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_frame();
    test_saturation();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
